fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control.sv | 127 ++++++++++++
 tb/tb_fetch_control.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Instruction fetch sequencer: issues one memory read per instruction, holds the
// returned window for decode and advances the PC by the decoded length.
module fetch_control #(
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       FETCH_BYTES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     stall_pc,
  input  logic                     stall_phase,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic [3:0]               dec_len,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [8*FETCH_BYTES-1:0] imem_data,
  output logic                     fetch_valid,
  output logic [ADDR_W-1:0]        fetch_pc,
  output logic [8*FETCH_BYTES-1:0] fetch_bytes,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int unsigned DATA_W = 8 * FETCH_BYTES;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_DATA,
    ST_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              imem_req_d;
  logic [ADDR_W-1:0] imem_addr_d;
  logic              fetch_valid_d;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [DATA_W-1:0] fetch_bytes_d;
  logic [CNT_W-1:0]  stall_cycles_d;

  logic              stalled;
  logic [ADDR_W-1:0] step_len;
  logic [ADDR_W-1:0] next_pc;

  assign stalled  = stall_pc | stall_phase;
  // A zero length from decode would lock the PC in place, so it advances by one.
  assign step_len = (dec_len == 4'd0) ? ADDR_W'(1) : ADDR_W'(dec_len);
  assign next_pc  = fetch_pc + step_len;

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    imem_req_d     = imem_req;
    imem_addr_d    = imem_addr;
    fetch_valid_d  = fetch_valid;
    fetch_pc_d     = fetch_pc;
    fetch_bytes_d  = fetch_bytes;
    stall_cycles_d = stall_cycles;

    if (redirect) begin
      state_d       = ST_REQ;
      pc_d          = redirect_pc;
      fetch_valid_d = 1'b0;
      imem_req_d    = 1'b1;
      imem_addr_d   = redirect_pc;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d     = ST_REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
        end
        // Whatever sits on imem_data now belongs to no live request: ignore it.
        ST_REQ: begin
          state_d    = ST_DATA;
          imem_req_d = 1'b0;
        end
        ST_DATA: begin
          state_d       = ST_HOLD;
          fetch_bytes_d = imem_data;
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
        end
        ST_HOLD: begin
          if (fetch_valid && !stalled) begin
            state_d       = ST_REQ;
            pc_d          = next_pc;
            fetch_valid_d = 1'b0;
            imem_req_d    = 1'b1;
            imem_addr_d   = next_pc;
          end else if (fetch_valid && stalled && (stall_cycles != '1)) begin
            stall_cycles_d = stall_cycles + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
      fetch_valid  <= 1'b0;
      fetch_pc     <= '0;
      fetch_bytes  <= '0;
      stall_cycles <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req     <= imem_req_d;
      imem_addr    <= imem_addr_d;
      fetch_valid  <= fetch_valid_d;
      fetch_pc     <= fetch_pc_d;
      fetch_bytes  <= fetch_bytes_d;
      stall_cycles <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Directed plus randomized bench for fetch_control, checked against a
// cycle-level behavioural model of the fetch rules.
module tb_fetch_control;

  localparam int unsigned      AW  = 64;
  localparam int unsigned      FB  = 16;
  localparam int unsigned      CW  = 6;
  localparam logic [AW-1:0]    RPC = 64'h1000;
  localparam logic [8*FB-1:0]  AA_FILL = {16{8'hAA}};

  logic            clk = 1'b0;
  logic            rstn;
  logic            stall_pc, stall_phase, redirect;
  logic [AW-1:0]   redirect_pc;
  logic [3:0]      dec_len;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic [8*FB-1:0] imem_data;
  logic            fetch_valid;
  logic [AW-1:0]   fetch_pc;
  logic [8*FB-1:0] fetch_bytes;
  logic [CW-1:0]   stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what each output must show in the current cycle.
  bit              m_boot, m_due, m_req, m_valid;
  logic [AW-1:0]   m_pc, m_addr, m_fpc;
  logic [8*FB-1:0] m_bytes;
  logic [CW-1:0]   m_cnt;
  bit              last_req;
  logic [AW-1:0]   last_addr;

  fetch_control #(
    .ADDR_W(AW), .FETCH_BYTES(FB), .RESET_PC(RPC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .stall_pc(stall_pc), .stall_phase(stall_phase),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_len(dec_len),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_bytes(fetch_bytes),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [8*FB-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 64'hC3C3_5A5A_0F0F_9696, ~a + 64'h1234};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_req",     128'(imem_req),     128'(m_req));
    check("imem_addr",    128'(imem_addr),    128'(m_addr));
    check("fetch_valid",  128'(fetch_valid),  128'(m_valid));
    check("fetch_pc",     128'(fetch_pc),     128'(m_fpc));
    check("fetch_bytes",  fetch_bytes,        m_bytes);
    check("stall_cycles", 128'(stall_cycles), 128'(m_cnt));
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_due = 1'b0; m_req = 1'b0; m_valid = 1'b0;
    m_pc = RPC; m_addr = '0; m_fpc = '0; m_bytes = '0; m_cnt = '0;
    last_req = 1'b0; last_addr = '0;
  endtask

  // Applies the fetch rules for one rising edge using the inputs just driven.
  task automatic model_edge();
    bit            stall, due_next;
    logic [AW-1:0] nxt;
    stall     = stall_pc | stall_phase;
    due_next  = m_req && !redirect;
    last_req  = m_req;
    last_addr = m_addr;
    if (redirect) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_req = 1'b1; m_addr = redirect_pc;
    end else if (m_boot) begin
      m_req = 1'b1; m_addr = m_pc;
    end else if (m_due) begin
      m_bytes = imem_data; m_fpc = m_pc; m_valid = 1'b1; m_req = 1'b0;
    end else if (m_valid && !stall) begin
      nxt = m_fpc + ((dec_len == 4'd0) ? 64'd1 : 64'(dec_len));
      m_pc = nxt; m_valid = 1'b0; m_req = 1'b1; m_addr = nxt;
    end else begin
      m_req = 1'b0;
      if (m_valid && stall && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    m_boot = 1'b0;
    m_due  = due_next;
  endtask

  // One clock: drive inputs just after an edge, advance, compare 1 time unit later.
  task automatic step(input logic sp, input logic sph, input logic rd,
                      input logic [AW-1:0] rpc, input logic [3:0] len, input bit aa);
    stall_pc = sp; stall_phase = sph; redirect = rd; redirect_pc = rpc; dec_len = len;
    if (aa)            imem_data = AA_FILL;
    else if (last_req) imem_data = mem_word(last_addr);
    else               imem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rstn = 1'b1; stall_pc = 1'b0; stall_phase = 1'b0; redirect = 1'b0;
    redirect_pc = '0; dec_len = '0; imem_data = '0;
    #1 rstn = 1'b0;
    model_reset();
    #2 check_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Boot: request in cycle 2, window valid in cycle 4.
    step(0, 0, 0, '0, 4'd0, 0);
    check("boot_req", 128'(imem_req), 128'(1));
    check("boot_addr", 128'(imem_addr), 128'(64'h1000));
    step(0, 0, 0, '0, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);
    check("boot_valid", 128'(fetch_valid), 128'(1));
    check("boot_fpc", 128'(fetch_pc), 128'(64'h1000));

    // Consume with length 3.
    step(0, 0, 0, '0, 4'd3, 0);
    check("len3_addr", 128'(imem_addr), 128'(64'h1003));
    step(0, 0, 0, '0, 4'd3, 0);
    step(0, 0, 0, '0, 4'd3, 0);
    check("len3_fpc", 128'(fetch_pc), 128'(64'h1003));

    // Five stall_pc cycles then two stall_phase cycles, then consume.
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0, 4'd9, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, '0, 4'd9, 0);
    check("stall_count7", 128'(stall_cycles), 128'(7));
    check("stall_frozen", 128'(fetch_pc), 128'(64'h1003));
    step(0, 0, 0, '0, 4'd2, 0);
    check("free_req", 128'(imem_req), 128'(1));
    check("free_addr", 128'(imem_addr), 128'(64'h1005));

    // Redirect during the request cycle while stale 0xAA data is on the bus.
    step(0, 0, 1, 64'h2000, 4'd0, 1);
    check("redir_req_addr", 128'(imem_addr), 128'(64'h2000));
    step(0, 0, 0, '0, 4'd0, 1);
    step(0, 0, 0, '0, 4'd0, 0);
    check("redir_fpc", 128'(fetch_pc), 128'(64'h2000));
    check("redir_bytes", fetch_bytes, mem_word(64'h2000));

    // Redirect from hold beats a would-be consume of length 5.
    step(0, 0, 1, 64'h3000, 4'd5, 0);
    check("hold_redir_addr", 128'(imem_addr), 128'(64'h3000));
    check("hold_redir_valid", 128'(fetch_valid), 128'(0));
    step(0, 0, 0, '0, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);

    // PC wrap from all-ones, then zero-length treated as one.
    step(0, 0, 1, '1, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);
    check("wrap_fpc", 128'(fetch_pc), 128'({AW{1'b1}}));
    step(0, 0, 0, '0, 4'd1, 0);
    check("wrap_addr", 128'(imem_addr), 128'(64'h0));
    step(0, 0, 0, '0, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);
    check("len0_addr", 128'(imem_addr), 128'(64'h1));
    step(0, 0, 0, '0, 4'd0, 0);
    step(0, 0, 0, '0, 4'd0, 0);

    // Saturate the stall counter and keep stalling.
    for (int i = 0; i < 70; i++) step(1, 0, 0, '0, 4'd4, 0);
    check("cnt_sat", 128'(stall_cycles), 128'({CW{1'b1}}));
    step(1, 1, 0, '0, 4'd4, 0);
    check("cnt_sat_hold", 128'(stall_cycles), 128'({CW{1'b1}}));

    // Reset in the middle of a read, then restart from RESET_PC.
    step(0, 0, 0, '0, 4'd4, 0);
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    rstn = 1'b1;
    step(0, 0, 0, '0, 4'd0, 0);
    check("rst_req", 128'(imem_req), 128'(1));
    check("rst_addr", 128'(imem_addr), 128'(64'h1000));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) < 2),
           logic'($urandom_range(0, 15) == 0), {$urandom(), $urandom()},
           4'($urandom_range(0, 15)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
